serial_word_loader: RTL and testbench

- Serial-to-parallel deserializer that assembles a p_WIDTH-bit word from a bit stream.
- Presents the word on o_D with a one-cycle o_Load pulse, wired directly to the i_D/i_Load inputs of the downstream Register.
- Upstream stage of the Register: it writes the register only when a complete, valid frame has been received.

---
 rtl/serial_word_loader_pkg.sv | 21 ++
 rtl/serial_word_loader.sv | 160 ++++++++++++++++
 tb/tb_serial_word_loader.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/serial_word_loader_pkg.sv
// serial_word_loader_pkg: shared types and helpers for serial_word_loader.
//   state_t    - FSM states (PARITY is only reachable when
//                SERIAL_WORD_LOADER_PARITY_EN is defined)
//   STATE_W    - state encoding width
//   cnt_width  - bit-counter width able to hold the value w
package serial_word_loader_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    LOAD   = 2'd3
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_word_loader.sv
// serial_word_loader: serial-to-parallel deserializer feeding a Register.
// Assembles p_WIDTH bits (first bit flagged by i_Start) and presents the word
// on o_D with a one-cycle o_Load strobe.
//
// Optional feature macro: SERIAL_WORD_LOADER_PARITY_EN
//   defined   -> one extra even-parity bit follows the data; a mismatch
//                produces a one-cycle o_Error instead of o_Load.
//   undefined -> no parity stage, o_Error tied low.
//
// Ports:
//   i_Clk    - clock, rising edge
//   i_Rst    - asynchronous reset, active low
//   i_Serial - serial data bit (sampled when i_Valid=1)
//   i_Valid  - i_Serial carries a bit this cycle
//   i_Start  - with i_Valid: first bit of a frame (restarts a frame in progress)
//   o_D      - assembled word, held until the next completed frame or reset
//   o_Load   - one-cycle load strobe for the downstream Register
//   o_Busy   - frame in progress or being delivered
//   o_Error  - one-cycle parity-error strobe
module serial_word_loader
  import serial_word_loader_pkg::*;
#(
  parameter int unsigned p_WIDTH     = 32,
  parameter bit          p_MSB_FIRST = 1'b1
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic               i_Serial,
  input  logic               i_Valid,
  input  logic               i_Start,
  output logic [p_WIDTH-1:0] o_D,
  output logic               o_Load,
  output logic               o_Busy,
  output logic               o_Error
);

  localparam int unsigned    CW       = cnt_width(p_WIDTH);
  localparam logic [CW-1:0]  LAST_CNT = CW'(p_WIDTH - 1);

  state_t               r_state, w_state_nxt;
  logic [CW-1:0]        r_cnt, w_cnt_nxt;
  logic [p_WIDTH-1:0]   r_shift, w_shift_nxt;
  logic [p_WIDTH-1:0]   r_D, w_D_nxt;
  logic [p_WIDTH-1:0]   w_shift_cap, w_shift_fresh;

  function automatic logic [p_WIDTH-1:0] f_shift_in(input logic [p_WIDTH-1:0] v,
                                                    input logic b);
    if (p_MSB_FIRST) return {v[p_WIDTH-2:0], b};
    else             return {b, v[p_WIDTH-1:1]};
  endfunction

  assign w_shift_cap   = f_shift_in(r_shift, i_Serial);
  // A start bit always begins from an empty word, discarding any partial one.
  assign w_shift_fresh = f_shift_in('0, i_Serial);

`ifdef SERIAL_WORD_LOADER_PARITY_EN
  logic r_err, w_err_nxt;
  logic w_par_ok;
  assign w_par_ok = ~(^r_shift ^ i_Serial);
`endif

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_D_nxt     = r_D;
`ifdef SERIAL_WORD_LOADER_PARITY_EN
    w_err_nxt   = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (i_Valid && i_Start) begin
          w_shift_nxt = w_shift_fresh;
          w_cnt_nxt   = CW'(1);
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (i_Valid) begin
          if (i_Start) begin
            w_shift_nxt = w_shift_fresh;
            w_cnt_nxt   = CW'(1);
          end else begin
            w_shift_nxt = w_shift_cap;
            w_cnt_nxt   = r_cnt + CW'(1);
            if (r_cnt == LAST_CNT) begin
`ifdef SERIAL_WORD_LOADER_PARITY_EN
              w_state_nxt = PARITY;
`else
              // o_D is updated on the final capture edge so it is already
              // valid during the LOAD cycle.
              w_D_nxt     = w_shift_cap;
              w_state_nxt = LOAD;
`endif
            end
          end
        end
      end
`ifdef SERIAL_WORD_LOADER_PARITY_EN
      PARITY: begin
        if (i_Valid) begin
          if (i_Start) begin
            w_shift_nxt = w_shift_fresh;
            w_cnt_nxt   = CW'(1);
            w_state_nxt = SHIFT;
          end else if (w_par_ok) begin
            w_D_nxt     = r_shift;
            w_state_nxt = LOAD;
          end else begin
            w_err_nxt   = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = IDLE;
          end
        end
      end
`endif
      LOAD: begin
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_cnt   <= '0;
      r_shift <= '0;
      r_D     <= '0;
`ifdef SERIAL_WORD_LOADER_PARITY_EN
      r_err   <= 1'b0;
`endif
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
      r_D     <= w_D_nxt;
`ifdef SERIAL_WORD_LOADER_PARITY_EN
      r_err   <= w_err_nxt;
`endif
    end
  end

  assign o_D    = r_D;
  assign o_Load = (r_state == LOAD);
  assign o_Busy = (r_state != IDLE);
`ifdef SERIAL_WORD_LOADER_PARITY_EN
  assign o_Error = r_err;
`else
  assign o_Error = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_loader.sv
module tb_serial_word_loader;

`ifdef SERIAL_WORD_LOADER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ser, vld, sta;
  logic [31:0] d_m, d_l;
  logic        ld_m, ld_l, bsy_m, bsy_l, err_m, err_l;

  int          total = 0;
  int          bad   = 0;
  int          n_err_m = 0;
  int          exp_err = 0;
  logic [31:0] q_m[$];
  logic [31:0] q_l[$];
  logic [31:0] hold_m = '0;
  logic [31:0] hold_l = '0;

  always #5 clk = ~clk;

  serial_word_loader #(.p_WIDTH(32), .p_MSB_FIRST(1'b1)) dut_msb (
    .i_Clk(clk), .i_Rst(rst_n), .i_Serial(ser), .i_Valid(vld), .i_Start(sta),
    .o_D(d_m), .o_Load(ld_m), .o_Busy(bsy_m), .o_Error(err_m)
  );

  serial_word_loader #(.p_WIDTH(32), .p_MSB_FIRST(1'b0)) dut_lsb (
    .i_Clk(clk), .i_Rst(rst_n), .i_Serial(ser), .i_Valid(vld), .i_Start(sta),
    .o_D(d_l), .o_Load(ld_l), .o_Busy(bsy_l), .o_Error(err_l)
  );

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // Scoreboard: every load pops the next expected word; between loads o_D must hold.
  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst_n) begin
      hold_m = '0;
      hold_l = '0;
    end
    chk1("load_err_exclusive", ld_m & err_m, 1'b0);
    chk1("busy_match_lsb", bsy_l, bsy_m);
    chk1("err_match_lsb", err_l, err_m);
    if (ld_m) begin
      if (q_m.size() == 0) chk1("unexpected_load_msb", ld_m, 1'b0);
      else begin
        e = q_m.pop_front();
        chk32("word_msb", d_m, e);
        hold_m = e;
      end
    end else chk32("hold_msb", d_m, hold_m);
    if (ld_l) begin
      if (q_l.size() == 0) chk1("unexpected_load_lsb", ld_l, 1'b0);
      else begin
        e = q_l.pop_front();
        chk32("word_lsb", d_l, e);
        hold_l = e;
      end
    end else chk32("hold_lsb", d_l, hold_l);
    if (err_m) n_err_m++;
  end

  task automatic step(input logic v, input logic s, input logic b);
    vld = v; sta = s; ser = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [31:0] w, input bit gaps, input bit par_good);
    if (!PAR || par_good) begin
      q_m.push_back(w);
      q_l.push_back(rev32(w));
    end else exp_err++;
    for (int i = 31; i >= 0; i--) begin
      if (gaps) repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, 1'($urandom));
      step(1'b1, (i == 31), w[i]);
      if (i == 31) chk1("busy_after_start", bsy_m, 1'b1);
    end
    if (PAR) step(1'b1, 1'b0, par_good ? ^w : ~^w);
  endtask

  task automatic end_frame(input bit exp_load, input logic [31:0] exp_d,
                           input logic v_in, input logic s_in);
    chk1("load_latency", ld_m, exp_load);
    chk1("load_latency_lsb", ld_l, exp_load);
    chk1("busy_in_load", bsy_m, exp_load);
    chk1("err_strobe", err_m, ~exp_load);
    if (exp_load) begin
      chk32("d_at_load", d_m, exp_d);
      chk32("d_at_load_lsb", d_l, rev32(exp_d));
    end
    step(v_in, s_in, 1'b1);
    chk1("load_one_cycle", ld_m, 1'b0);
    chk1("busy_after_load", bsy_m, 1'b0);
    chk1("err_one_cycle", err_m, 1'b0);
  endtask

  initial begin
    logic [31:0] w;
    rst_n = 1'b0; vld = 1'b0; sta = 1'b0; ser = 1'b0;
    #1;
    chk32("reset_d", d_m, 32'h0);
    chk1("reset_load", ld_m, 1'b0);
    chk1("reset_busy", bsy_m, 1'b0);
    chk1("reset_err", err_m, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0);

    // Single-bit MSB word, continuous valid; LSB instance sees 0x1.
    send_frame(32'h8000_0000, 1'b0, 1'b1);
    end_frame(1'b1, 32'h8000_0000, 1'b0, 1'b0);

    // Same word with gaps; start bit driven during LOAD must be ignored.
    send_frame(32'h8000_0000, 1'b1, 1'b1);
    end_frame(1'b1, 32'h8000_0000, 1'b1, 1'b1);
    repeat (34) step(1'b1, 1'b0, 1'b1);
    chk1("idle_ignores_nonstart", bsy_m, 1'b0);
    send_frame(32'h8004_0000, 1'b1, 1'b1);
    end_frame(1'b1, 32'h8004_0000, 1'b0, 1'b0);

    // Restart at bit 10 of a partial frame.
    w = 32'h8008_0000;
    for (int i = 31; i >= 22; i--) step(1'b1, (i == 31), w[i]);
    chk1("busy_partial", bsy_m, 1'b1);
    send_frame(32'h0000_00FF, 1'b0, 1'b1);
    end_frame(1'b1, 32'h0000_00FF, 1'b0, 1'b0);

    // Asynchronous reset at bit 20 discards the frame.
    w = 32'h1234_5678;
    for (int i = 31; i >= 12; i--) step(1'b1, (i == 31), w[i]);
    chk1("busy_before_reset", bsy_m, 1'b1);
    rst_n = 1'b0;
    #1;
    chk32("async_reset_d", d_m, 32'h0);
    chk32("async_reset_d_lsb", d_l, 32'h0);
    chk1("async_reset_busy", bsy_m, 1'b0);
    chk1("async_reset_load", ld_m, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    send_frame(32'hA5C3_0F81, 1'b1, 1'b1);
    end_frame(1'b1, 32'hA5C3_0F81, 1'b0, 1'b0);

`ifdef SERIAL_WORD_LOADER_PARITY_EN
    send_frame(32'hFFFF_FFFF, 1'b0, 1'b1);
    end_frame(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    send_frame(32'hFFFF_FFFF, 1'b0, 1'b0);
    end_frame(1'b0, 32'h0, 1'b0, 1'b0);
    send_frame(32'h1234_5678, 1'b1, 1'b0);
    end_frame(1'b0, 32'h0, 1'b0, 1'b0);
    chk32("d_held_after_error", d_m, 32'hFFFF_FFFF);
`endif

    repeat (3) step(1'b0, 1'b0, 1'b0);
    chk32("pending_msb", 32'(q_m.size()), 32'h0);
    chk32("pending_lsb", 32'(q_l.size()), 32'h0);
    chk32("error_count", 32'(n_err_m), 32'(exp_err));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
